in256_out1536_pack: RTL and testbench



---
 rtl/in256_out1536_pack.sv | 134 +++++++++++++
 tb/tb_in256_out1536_pack.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/in256_out1536_pack.sv
// rtl/in256_out1536_pack.sv - packs 128/256-bit stream beats into 1536-bit words
// Optional feature macro: PACK_TLAST_EN (honor s_in_tlast for early word completion).
module in256_out1536_pack (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [255:0]  s_in_tdata,
  input  logic          s_in_tvalid,
  output logic          s_in_tready,
  input  logic          s_in_tlast,
  output logic [1535:0] m_out_tdata,
  output logic          m_out_tvalid,
  input  logic          m_out_tready,
  output logic          m_out_tlast
);

  typedef enum logic {FILL, HOLD} acc_state_e;

  acc_state_e     acc_state_q, acc_state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic [1535:0]  acc_q, acc_d;
  logic           acc_last_q, acc_last_d;
  logic [1535:0]  out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;

  logic           beat_tlast;
  logic           beat_mode;
  logic           accept;
  logic           out_drain;
  logic           out_free;
  logic           word_done;
  logic [3:0]     last_cnt;
  logic [10:0]    shamt;
  logic [1535:0]  beat_ext;
  logic [1535:0]  acc_merged;

`ifdef PACK_TLAST_EN
  assign beat_tlast = s_in_tlast;
`else
  logic unused_tlast;
  assign unused_tlast = s_in_tlast;
  assign beat_tlast   = 1'b0;
`endif

  assign s_in_tready = (acc_state_q == FILL) & ~rst;
  assign accept      = s_in_tvalid & s_in_tready;
  assign out_drain   = out_valid_q & m_out_tready;
  assign out_free    = ~out_valid_q | m_out_tready;

  // The first beat of a word samples the live mode; later beats use the latched one.
  assign beat_mode  = (cnt_q == 4'd0) ? mode : mode_q;
  assign last_cnt   = beat_mode ? 4'd5 : 4'd11;
  assign word_done  = (cnt_q == last_cnt) | beat_tlast;
  assign shamt      = beat_mode ? {cnt_q[2:0], 8'd0} : {cnt_q, 7'd0};
  assign beat_ext   = beat_mode ? {1280'd0, s_in_tdata} : {1408'd0, s_in_tdata[127:0]};
  assign acc_merged = acc_q | (beat_ext << shamt);

  assign m_out_tdata  = out_data_q;
  assign m_out_tvalid = out_valid_q;
  assign m_out_tlast  = out_last_q;

  always_comb begin
    acc_state_d = acc_state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    acc_last_d  = acc_last_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_drain ? 1'b0 : out_valid_q;

    case (acc_state_q)
      FILL: begin
        if (accept) begin
          mode_d = beat_mode;
          if (word_done) begin
            cnt_d = 4'd0;
            if (out_free) begin
              out_data_d  = acc_merged;
              out_last_d  = beat_tlast;
              out_valid_d = 1'b1;
              acc_d       = '0;
              acc_last_d  = 1'b0;
            end else begin
              acc_d       = acc_merged;
              acc_last_d  = beat_tlast;
              acc_state_d = HOLD;
            end
          end else begin
            acc_d = acc_merged;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      HOLD: begin
        if (out_drain) begin
          out_data_d  = acc_q;
          out_last_d  = acc_last_q;
          out_valid_d = 1'b1;
          acc_d       = '0;
          acc_last_d  = 1'b0;
          cnt_d       = 4'd0;
          acc_state_d = FILL;
        end
      end
      default: acc_state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_state_q <= FILL;
      cnt_q       <= 4'd0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      acc_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      acc_state_q <= acc_state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      acc_last_q  <= acc_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_in256_out1536_pack.sv
// tb/tb_in256_out1536_pack.sv - randomized self-checking bench for in256_out1536_pack
module tb_in256_out1536_pack;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [255:0]  s_in_tdata;
  logic          s_in_tvalid;
  logic          s_in_tready;
  logic          s_in_tlast;
  logic [1535:0] m_out_tdata;
  logic          m_out_tvalid;
  logic          m_out_tready;
  logic          m_out_tlast;

  int total = 0;
  int bad   = 0;

`ifdef PACK_TLAST_EN
  localparam bit TL_EN = 1'b1;
`else
  localparam bit TL_EN = 1'b0;
`endif

  in256_out1536_pack dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .s_in_tdata   (s_in_tdata),
    .s_in_tvalid  (s_in_tvalid),
    .s_in_tready  (s_in_tready),
    .s_in_tlast   (s_in_tlast),
    .m_out_tdata  (m_out_tdata),
    .m_out_tvalid (m_out_tvalid),
    .m_out_tready (m_out_tready),
    .m_out_tlast  (m_out_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compares a whole word as one check, reporting the first differing 64-bit chunk.
  task automatic chk_word(input string tag, input logic [1535:0] got, input logic [1535:0] exp);
    int idx = 0;
    for (int i = 23; i >= 0; i--)
      if (got[i*64 +: 64] !== exp[i*64 +: 64]) idx = i;
    chk($sformatf("%s[chunk%0d]", tag, idx), got[idx*64 +: 64], exp[idx*64 +: 64]);
  endtask

  // Reference model: words in flight and the word being assembled.
  logic [1535:0] exp_q[$];
  logic          exp_last_q[$];
  logic [1535:0] cw;
  int            ci;
  logic          cm;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_last_q.delete();
      cw = '0;
      ci = 0;
      cm = 1'b0;
    end else begin
      chk("in_ready", 64'(s_in_tready), 64'(exp_q.size() < 2));
      chk("out_valid", 64'(m_out_tvalid), 64'(exp_q.size() > 0));
      if (m_out_tvalid && m_out_tready && exp_q.size() > 0) begin
        chk_word("out_data", m_out_tdata, exp_q[0]);
        chk("out_last", 64'(m_out_tlast), 64'(exp_last_q[0]));
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
      end
      if (s_in_tvalid && s_in_tready) begin
        if (ci == 0) cm = mode;
        if (cm) cw[ci*256 +: 256] = s_in_tdata;
        else    cw[ci*128 +: 128] = s_in_tdata[127:0];
        ci++;
        if (ci == (cm ? 6 : 12) || (TL_EN && s_in_tlast)) begin
          exp_q.push_back(cw);
          exp_last_q.push_back(TL_EN && s_in_tlast);
          cw = '0;
          ci = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send(input logic [255:0] d, input logic l);
    int   n = 0;
    logic acc;
    s_in_tdata  = d;
    s_in_tlast  = l;
    s_in_tvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = s_in_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    s_in_tvalid = 1'b0;
    s_in_tlast  = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [1535:0] w;

  initial begin
    rst          = 1'b1;
    mode         = 1'b0;
    s_in_tdata   = '0;
    s_in_tvalid  = 1'b0;
    s_in_tlast   = 1'b0;
    m_out_tready = 1'b1;
    step(3);
    chk("rst_valid", 64'(m_out_tvalid), 64'd0);
    chk("rst_ready", 64'(s_in_tready), 64'd0);
    chk("rst_last", 64'(m_out_tlast), 64'd0);
    chk_word("rst_data", m_out_tdata, '0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(s_in_tready), 64'd1);

    // 6 beats of 1..6 in 256-bit mode
    mode = 1'b1;
    w = '0;
    for (int k = 0; k < 6; k++) begin
      send(256'(k + 1), 1'b0);
      w[k*256 +: 256] = 256'(k + 1);
    end
    chk("t1_valid", 64'(m_out_tvalid), 64'd1);
    chk_word("t1_data", m_out_tdata, w);

    // 12 beats in 128-bit mode; upper input half must be dropped
    mode = 1'b0;
    w = '0;
    for (int k = 0; k < 12; k++) begin
      send({128'hFF, 128'(8'hA0 + k)}, 1'b0);
      w[k*128 +: 128] = 128'(8'hA0 + k);
    end
    chk("t2_valid", 64'(m_out_tvalid), 64'd1);
    chk_word("t2_data", m_out_tdata, w);

    // tlast on beat 3 of a 256-bit word
    mode = 1'b1;
    w = '0;
    for (int k = 0; k < 3; k++) begin
      send(256'(8'h11 * (k + 1)), k == 2);
      w[k*256 +: 256] = 256'(8'h11 * (k + 1));
    end
    if (!TL_EN) begin
      for (int k = 3; k < 6; k++) begin
        send(256'(8'h11 * (k + 1)), 1'b0);
        w[k*256 +: 256] = 256'(8'h11 * (k + 1));
      end
    end
    chk("t3_valid", 64'(m_out_tvalid), 64'd1);
    chk("t3_last", 64'(m_out_tlast), 64'(TL_EN));
    chk_word("t3_data", m_out_tdata, w);

    // Backpressure: two words fill, then input stalls in HOLD
    step(2);
    m_out_tready = 1'b0;
    w = '0;
    for (int k = 0; k < 12; k++) begin
      send(256'(16'h5000 + k), 1'b0);
      if (k < 6) w[k*256 +: 256] = 256'(16'h5000 + k);
    end
    step(8);
    chk("t4_hold_ready", 64'(s_in_tready), 64'd0);
    chk("t4_hold_valid", 64'(m_out_tvalid), 64'd1);
    chk_word("t4_hold_data", m_out_tdata, w);
    m_out_tready = 1'b1;
    step(2);
    chk("t4_release_ready", 64'(s_in_tready), 64'd1);
    chk("t4_release_valid", 64'(m_out_tvalid), 64'd0);

    // Mode changed mid-word is ignored until the word completes
    mode = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) mode = 1'b1;
      send(256'(16'h7700 + k), 1'b0);
      if (k == 10) chk("t5_not_early", 64'(m_out_tvalid), 64'd0);
    end
    chk("t5_valid", 64'(m_out_tvalid), 64'd1);
    for (int k = 0; k < 6; k++) send(256'(16'h7800 + k), 1'b0);
    chk("t5_next_valid", 64'(m_out_tvalid), 64'd1);

    // Reset mid-word discards partial data
    step(2);
    for (int k = 0; k < 3; k++) send(256'(16'hDEAD), 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_no_output", 64'(m_out_tvalid), 64'd0);
    w = '0;
    for (int k = 0; k < 6; k++) begin
      send(256'(12'h100 + k), 1'b0);
      w[k*256 +: 256] = 256'(12'h100 + k);
    end
    chk_word("t6_data", m_out_tdata, w);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 599) == 0);
      mode         = $urandom_range(0, 1);
      s_in_tvalid  = ($urandom_range(0, 9) < 7);
      s_in_tlast   = ($urandom_range(0, 7) == 0);
      s_in_tdata   = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
      m_out_tready = ($urandom_range(0, 9) < 6);
      step(1);
    end
    s_in_tvalid  = 1'b0;
    rst          = 1'b0;
    m_out_tready = 1'b1;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
